// File: rtl/opr_dispatch_pkg.sv
// Select codes, channel indices and target decode helpers for the operand dispatcher.
package opr_pkg;

    localparam int OPR_SEL_W = 3;
    localparam int OPR_N_CH  = 6;

    localparam logic [OPR_SEL_W-1:0] OPR_NONE    = 3'd0;
    localparam logic [OPR_SEL_W-1:0] OPR_AWM     = 3'd1;
    localparam logic [OPR_SEL_W-1:0] OPR_ACI_AWM = 3'd2;
    localparam logic [OPR_SEL_W-1:0] OPR_INC     = 3'd3;
    localparam logic [OPR_SEL_W-1:0] OPR_DEC     = 3'd4;
    localparam logic [OPR_SEL_W-1:0] OPR_PC      = 3'd5;
    localparam logic [OPR_SEL_W-1:0] OPR_RST     = 3'd6;

    localparam int CH_ACI = 0;
    localparam int CH_AWM = 1;
    localparam int CH_INC = 2;
    localparam int CH_DEC = 3;
    localparam int CH_PC  = 4;
    localparam int CH_RST = 5;

    // Channels written by a code; the split code is the only two-hot entry.
    function automatic logic [OPR_N_CH-1:0] opr_target_mask(input logic [OPR_SEL_W-1:0] sel);
        logic [OPR_N_CH-1:0] m;
        m = '0;
        case (sel)
            OPR_AWM:     m[CH_AWM] = 1'b1;
            OPR_ACI_AWM: begin
                m[CH_ACI] = 1'b1;
                m[CH_AWM] = 1'b1;
            end
            OPR_INC:     m[CH_INC] = 1'b1;
            OPR_DEC:     m[CH_DEC] = 1'b1;
            OPR_PC:      m[CH_PC]  = 1'b1;
            OPR_RST:     m[CH_RST] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

    function automatic logic opr_is_illegal(input logic [OPR_SEL_W-1:0] sel);
        return (sel > OPR_RST);
    endfunction

endpackage

// File: rtl/opr_dispatch_if.sv
// Operand bus between decode (master) and the dispatcher (slave), including channel outputs.
interface opr_dispatch_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 6,
    parameter int SEL_W  = 3,
    parameter int ERR_W  = 8
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and held data stays stable until that transfer.
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH-1:0]        ch_ready;
    logic                   err;
    logic [ERR_W-1:0]       err_cnt;

    modport master (
        output in_data, in_sel, in_valid, flush, ch_ready,
        input  in_ready, ch_data, ch_valid, err, err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, flush, ch_ready,
        output in_ready, ch_data, ch_valid, err, err_cnt
    );
endinterface

// File: rtl/opr_chan_reg.sv
// One destination channel: holds an operand until its consumer takes it.
module opr_chan_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              ready_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Flush beats load and drain; load beats drain so a same-edge reload keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/opr_dispatch.sv
// Routes an operand byte to one (or, for the split code, two) holding channels.
module opr_dispatch
    import opr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_CH     = OPR_N_CH,
    parameter int SEL_W    = OPR_SEL_W,
    parameter int SPLIT_LO = 5,
    parameter int ERR_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    opr_dispatch_if.slave bus
);
    logic [N_CH-1:0]        tgt_mask;
    logic [N_CH-1:0]        chan_free;
    logic [N_CH-1:0]        load;
    logic [N_CH-1:0]        chan_valid;
    logic [N_CH*DATA_W-1:0] chan_data;
    logic [DATA_W-1:0]      load_data [N_CH];
    logic                   in_ready;
    logic                   accept;
    logic                   is_split;
    logic                   err_q, err_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

    assign tgt_mask  = opr_target_mask(bus.in_sel);
    assign chan_free = ~chan_valid | bus.ch_ready;
    assign in_ready  = rst_n && !bus.flush && ((tgt_mask & ~chan_free) == '0);
    assign accept    = bus.in_valid && in_ready;
    assign load      = accept ? tgt_mask : '0;
    assign is_split  = (bus.in_sel == OPR_ACI_AWM);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            load_data[i] = bus.in_data;
        end
        if (is_split) begin
            load_data[CH_ACI] = DATA_W'(bus.in_data[SPLIT_LO-1:0]);
            load_data[CH_AWM] = DATA_W'(bus.in_data[DATA_W-1:SPLIT_LO]);
        end
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept && opr_is_illegal(bus.in_sel)) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        opr_chan_reg #(.DATA_W(DATA_W)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load[g]),
            .load_data_i (load_data[g]),
            .ready_i     (bus.ch_ready[g]),
            .flush_i     (bus.flush),
            .data_o      (chan_data[g*DATA_W +: DATA_W]),
            .valid_o     (chan_valid[g])
        );
    end

    assign bus.in_ready = in_ready;
    assign bus.ch_data  = chan_data;
    assign bus.ch_valid = chan_valid;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule
